// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA Montgomery multiply datapath.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: word/operand sizes, FSM state encoding, word_t/dword_t/cnt_t typedefs.
package rsa_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_LENGTH = 1024;
    localparam int NUM_WORDS   = DATA_LENGTH / DATA_WIDTH;
    // Counters must reach NUM_WORDS (the extra word of the final subtract).
    localparam int CNT_WIDTH   = $clog2(NUM_WORDS) + 1;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_MUL     = 3'd1;
    localparam logic [2:0] ENC_MUL_TOP = 3'd2;
    localparam logic [2:0] ENC_MQ      = 3'd3;
    localparam logic [2:0] ENC_RED     = 3'd4;
    localparam logic [2:0] ENC_RED_TOP = 3'd5;
    localparam logic [2:0] ENC_SUB     = 3'd6;
    localparam logic [2:0] ENC_DONE    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_MUL     = ENC_MUL,
        ST_MUL_TOP = ENC_MUL_TOP,
        ST_MQ      = ENC_MQ,
        ST_RED     = ENC_RED,
        ST_RED_TOP = ENC_RED_TOP,
        ST_SUB     = ENC_SUB,
        ST_DONE    = ENC_DONE
    } state_t;

    typedef logic [DATA_WIDTH-1:0]   word_t;
    typedef logic [2*DATA_WIDTH-1:0] dword_t;
    typedef logic [CNT_WIDTH-1:0]    cnt_t;

endpackage

// File: rtl/mont_mul_cios_if.sv
// Request/response bundle of the Montgomery multiplier.
// Latency: none (wiring only).
// Backpressure: none; start is only honoured while the core is idle.
// master drives start/a/b/n/n0prime; slave drives result/busy/done.
interface mont_mul_cios_if;
    import rsa_pkg::*;

    logic                   start;
    logic [DATA_LENGTH-1:0] a;
    logic [DATA_LENGTH-1:0] b;
    logic [DATA_LENGTH-1:0] n;
    word_t                  n0prime;
    logic [DATA_LENGTH-1:0] result;
    logic                   busy;
    logic                   done;

    modport master (output start, a, b, n, n0prime, input result, busy, done);
    modport slave  (input start, a, b, n, n0prime, output result, busy, done);

endinterface

// File: rtl/mont_mac_word.sv
// Word multiply-accumulate {C,S} = x + y*z + c, the single shared multiplier.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, z, c (w-bit) in; sum (2w-bit) out. Result never overflows 2w bits.
module mont_mac_word
    import rsa_pkg::*;
(
    input  word_t  x,
    input  word_t  y,
    input  word_t  z,
    input  word_t  c,
    output dword_t sum
);

    assign sum = dword_t'(x) + dword_t'(y) * dword_t'(z) + dword_t'(c);

endmodule

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^DATA_LENGTH.
// Latency: done 1 + s*(2s+3) cycles after accepted start; +s+1 with MONT_FINAL_SUB_EN.
// Backpressure: start is ignored while busy (and in the DONE cycle); no stalls once running.
// Ports: clk, rst_n (async active-low), bus (mont_mul_cios_if.slave). Macro: MONT_FINAL_SUB_EN.
module mont_mul_cios
    import rsa_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mont_mul_cios_if.slave bus
);

    localparam cnt_t LAST_WORD = cnt_t'(NUM_WORDS - 1);
    localparam cnt_t SUB_TOP   = cnt_t'(NUM_WORDS);
    localparam int   TOP       = NUM_WORDS * DATA_WIDTH;   // bit offset of t[s]

    state_t                              state;
    logic [DATA_LENGTH-1:0]              a_q, b_q, n_q, result_q;
    logic [(NUM_WORDS+2)*DATA_WIDTH-1:0] t_q;
    word_t                               n0p_q, m_q, c_q;
    cnt_t                                i_q, j_q, jm1;
    logic                                busy_q, done_q;

    logic [CNT_WIDTH-2:0] i_lo, j_lo;
    word_t                a_w, b_w, n_w, t_w, t_s, t_s1;
    word_t                mac_x, mac_y, mac_z, mac_c;
    dword_t               mac_sum;
    logic [DATA_WIDTH:0]  top_sum;

    assign i_lo = i_q[CNT_WIDTH-2:0];
    assign j_lo = j_q[CNT_WIDTH-2:0];
    assign jm1  = j_q - 1'b1;

    assign a_w  = a_q[j_lo*DATA_WIDTH +: DATA_WIDTH];
    assign b_w  = b_q[i_lo*DATA_WIDTH +: DATA_WIDTH];
    // n has no word s; the subtract treats it as zero there.
    assign n_w  = (j_q == SUB_TOP) ? '0 : n_q[j_lo*DATA_WIDTH +: DATA_WIDTH];
    assign t_w  = t_q[j_q*DATA_WIDTH +: DATA_WIDTH];
    assign t_s  = t_q[TOP +: DATA_WIDTH];
    assign t_s1 = t_q[TOP+DATA_WIDTH +: DATA_WIDTH];

    // Same adder closes both the multiply pass and the reduction pass.
    assign top_sum = {1'b0, t_s} + {1'b0, c_q};

`ifdef MONT_FINAL_SUB_EN
    logic                borrow_q;
    logic [DATA_WIDTH:0] sub_d;
    assign sub_d = {1'b0, t_w} - {1'b0, n_w} - {{DATA_WIDTH{1'b0}}, borrow_q};
`endif

    always_comb begin
        mac_x = '0;
        mac_y = '0;
        mac_z = '0;
        mac_c = '0;
        case (state)
            ST_MUL: begin
                mac_x = t_w;
                mac_y = a_w;
                mac_z = b_w;
                mac_c = c_q;
            end
            ST_MQ: begin
                mac_y = t_q[DATA_WIDTH-1:0];
                mac_z = n0p_q;
            end
            ST_RED: begin
                mac_x = t_w;
                mac_y = m_q;
                mac_z = n_w;
                mac_c = c_q;
            end
            default: ;
        endcase
    end

    mont_mac_word u_mac (
        .x   (mac_x),
        .y   (mac_y),
        .z   (mac_z),
        .c   (mac_c),
        .sum (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            n0p_q    <= '0;
            m_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MONT_FINAL_SUB_EN
            borrow_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        n_q    <= bus.n;
                        n0p_q  <= bus.n0prime;
                        t_q    <= '0;
                        c_q    <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    t_q[j_q*DATA_WIDTH +: DATA_WIDTH] <= mac_sum[DATA_WIDTH-1:0];
                    c_q <= mac_sum[2*DATA_WIDTH-1:DATA_WIDTH];
                    if (j_q == LAST_WORD) begin
                        j_q   <= '0;
                        state <= ST_MUL_TOP;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_MUL_TOP: begin
                    t_q[TOP +: 2*DATA_WIDTH] <= {{(DATA_WIDTH-1){1'b0}}, top_sum};
                    state <= ST_MQ;
                end
                ST_MQ: begin
                    m_q   <= mac_sum[DATA_WIDTH-1:0];
                    c_q   <= '0;
                    state <= ST_RED;
                end
                ST_RED: begin
                    // Word 0 of the reduction sum is zero by choice of m; it only feeds C.
                    if (j_q != '0) begin
                        t_q[jm1*DATA_WIDTH +: DATA_WIDTH] <= mac_sum[DATA_WIDTH-1:0];
                    end
                    c_q <= mac_sum[2*DATA_WIDTH-1:DATA_WIDTH];
                    if (j_q == LAST_WORD) begin
                        j_q   <= '0;
                        state <= ST_RED_TOP;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_RED_TOP: begin
                    t_q[TOP-DATA_WIDTH +: DATA_WIDTH] <= top_sum[DATA_WIDTH-1:0];
                    t_q[TOP +: DATA_WIDTH]            <= t_s1 + word_t'(top_sum[DATA_WIDTH]);
                    t_q[TOP+DATA_WIDTH +: DATA_WIDTH] <= '0;
                    c_q <= '0;
                    if (i_q == LAST_WORD) begin
`ifdef MONT_FINAL_SUB_EN
                        j_q      <= '0;
                        borrow_q <= 1'b0;
                        state    <= ST_SUB;
`else
                        state    <= ST_DONE;
`endif
                    end else begin
                        i_q   <= i_q + 1'b1;
                        state <= ST_MUL;
                    end
                end
`ifdef MONT_FINAL_SUB_EN
                ST_SUB: begin
                    // a is no longer needed, so its register holds d = t - n.
                    if (j_q != SUB_TOP) begin
                        a_q[j_lo*DATA_WIDTH +: DATA_WIDTH] <= sub_d[DATA_WIDTH-1:0];
                    end
                    borrow_q <= sub_d[DATA_WIDTH];
                    if (j_q == SUB_TOP) begin
                        state <= ST_DONE;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
`endif
                ST_DONE: begin
`ifdef MONT_FINAL_SUB_EN
                    result_q <= borrow_q ? t_q[DATA_LENGTH-1:0] : a_q;
`else
                    result_q <= t_q[DATA_LENGTH-1:0];
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_mont_mul_cios.sv
// Self-checking bench for mont_mul_cios against a whole-number REDC model.
// Latency: n/a.
// Backpressure: n/a. Honours MONT_FINAL_SUB_EN the same way as the design.
module tb_mont_mul_cios;
    import rsa_pkg::*;

    localparam int S = NUM_WORDS;
`ifdef MONT_FINAL_SUB_EN
    localparam int LAT = 1 + S*(2*S+3) + S + 1;
`else
    localparam int LAT = 1 + S*(2*S+3);
`endif

    typedef logic [DATA_LENGTH-1:0]   big_t;
    typedef logic [2*DATA_LENGTH+1:0] wide_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mont_mul_cios_if bus();

    mont_mul_cios dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    big_t n_mod;
    big_t np_full;
    word_t n0p;

    always @(posedge clk) cyc <= cyc + 1;

    // -n^-1 mod R by Newton iteration (each step doubles the correct low bits).
    function automatic big_t neg_inv(input big_t nn);
        big_t x = 1;
        for (int k = 0; k < 11; k++) x = x * (big_t'(2) - nn * x);
        return big_t'(0) - x;
    endfunction

    // REDC as integers: t = (ab + M*n)/R with M = ab*np mod R, then the output rule.
    function automatic big_t mont_ref(input big_t a, input big_t b);
        wide_t ab, mn, tt;
        big_t  m;
        ab = wide_t'(a) * wide_t'(b);
        m  = ab[DATA_LENGTH-1:0] * np_full;
        mn = wide_t'(m) * wide_t'(n_mod);
        tt = (ab + mn) >> DATA_LENGTH;
`ifdef MONT_FINAL_SUB_EN
        if (tt >= wide_t'(n_mod)) tt = tt - wide_t'(n_mod);
`endif
        // Without the final subtract only the low DATA_LENGTH bits survive.
        return tt[DATA_LENGTH-1:0];
    endfunction

    function automatic big_t rand_big();
        big_t v;
        for (int k = 0; k < S; k++) v[k*DATA_WIDTH +: DATA_WIDTH] = $urandom;
        return v;
    endfunction

    function automatic big_t rand_operand();
        big_t v;
        v = rand_big() >> $urandom_range(0, DATA_LENGTH - 8);
        if (v >= n_mod) v = n_mod - 1;
        return v;
    endfunction

    // Caller is at a sample point (1 unit after posedge) with the core idle.
    task automatic run_op(input big_t a, input big_t b, output int lat, output big_t res,
                          output bit busy_ok, output bit busy_at_done);
        lat = -1;
        res = '0;
        busy_ok = 1'b1;
        busy_at_done = 1'b1;
        bus.a = a; bus.b = b; bus.n = n_mod; bus.n0prime = n0p; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = rand_big(); bus.b = rand_big(); bus.n = rand_big(); bus.n0prime = $urandom;
        for (int k = 0; k <= LAT + 20; k++) begin
            if (bus.done) begin
                lat = k;
                res = bus.result;
                busy_at_done = bus.busy;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.result !== '0) $display("FAIL reset_result: got %h want 0", bus.result[127:0]);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat; big_t res, exp_r; bit bok, bad;
        exp_r = mont_ref(3, 7);
        run_op(3, 7, lat, res, bok, bad);
        n_checks++;
        if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (res !== exp_r) $display("FAIL basic_result: got %h want %h (low 128b)", res[127:0], exp_r[127:0]);
        else n_pass++;
        n_checks++;
        if (bok !== 1'b1) $display("FAIL basic_busy_held: busy dropped before done");
        else n_pass++;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", bad);
        else n_pass++;
    endtask

    task automatic test_top_carry();
        int lat; big_t res, exp_r, a; bit bok, bad;
        a = '0;
        a[DATA_LENGTH-1] = 1'b1;
        exp_r = mont_ref(a, 2);
        run_op(a, 2, lat, res, bok, bad);
        n_checks++;
        if (res !== exp_r) $display("FAIL top_carry_result: got %h want %h (low 128b)", res[127:0], exp_r[127:0]);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL top_carry_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    // With n = R-1 the product reaches t = R; the unreduced build drops t[s].
    task automatic test_max_operands();
        int lat; big_t res, exp_r, nm1; bit bok, bad;
        nm1 = n_mod - 1;
        exp_r = mont_ref(nm1, nm1);
        run_op(nm1, nm1, lat, res, bok, bad);
        n_checks++;
        if (res !== exp_r) $display("FAIL max_result: got %h want %h (low 128b)", res[127:0], exp_r[127:0]);
        else n_pass++;
    endtask

    task automatic test_zero_restart();
        int ndone = 0;
        int first = -1;
        big_t exp_r;
        exp_r = mont_ref(0, n_mod - 1);
        bus.a = '0; bus.b = n_mod - 1; bus.n = n_mod; bus.n0prime = n0p; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k <= 2*LAT + 20; k++) begin
            if (k == 10) begin
                bus.a = 3; bus.b = 7; bus.start = 1'b1;
            end
            if (k == 11) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first < 0) first = k;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone !== 1) $display("FAIL ignore_start_done_count: got %0d want 1", ndone);
        else n_pass++;
        n_checks++;
        if (first !== LAT) $display("FAIL zero_latency: got %0d want %0d", first, LAT);
        else n_pass++;
        n_checks++;
        if (bus.result !== exp_r) $display("FAIL zero_result: got %h want %h (low 128b)", bus.result[127:0], exp_r[127:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; big_t res, exp_r, a, b; bit bok, bad;
        for (int r = 0; r < 4; r++) begin
            a = rand_operand();
            b = rand_operand();
            exp_r = mont_ref(a, b);
            run_op(a, b, lat, res, bok, bad);
            n_checks++;
            if (res !== exp_r) $display("FAIL random%0d_result: got %h want %h (low 128b)", r, res[127:0], exp_r[127:0]);
            else n_pass++;
            n_checks++;
            if (lat !== LAT) $display("FAIL random%0d_latency: got %0d want %0d", r, lat, LAT);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        int ndone = 0;
        int lat; big_t res, exp_r; bit bok, bad;
        bus.a = 3; bus.b = 7; bus.n = n_mod; bus.n0prime = n0p; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (500) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.result !== '0) $display("FAIL midreset_result: got %h want 0", bus.result[127:0]);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", bus.busy);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 10; k++) begin
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", ndone);
        else n_pass++;
        exp_r = mont_ref(5, 5);
        run_op(5, 5, lat, res, bok, bad);
        n_checks++;
        if (res !== exp_r) $display("FAIL after_reset_result: got %h want %h (low 128b)", res[127:0], exp_r[127:0]);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL after_reset_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   times [3];
        big_t results [3];
        int   got = 0;
        big_t exp_r;
        exp_r = mont_ref(3, 7);
        bus.a = 3; bus.b = 7; bus.n = n_mod; bus.n0prime = n0p; bus.start = 1'b1;
        for (int k = 0; k < 3*(LAT+1) + 20 && got < 3; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                times[got]   = cyc;
                results[got] = bus.result;
                got++;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (got !== 3) $display("FAIL b2b_done_count: got %0d want 3", got);
        else n_pass++;
        for (int r = 0; r < got; r++) begin
            n_checks++;
            if (results[r] !== exp_r) $display("FAIL b2b_result%0d: got %h want %h (low 128b)", r, results[r][127:0], exp_r[127:0]);
            else n_pass++;
        end
        for (int r = 1; r < got; r++) begin
            n_checks++;
            if (times[r] - times[r-1] !== LAT + 1)
                $display("FAIL b2b_period%0d: got %0d want %0d", r, times[r] - times[r-1], LAT + 1);
            else n_pass++;
        end
        // Let any operation accepted on the last done cycle drain.
        repeat (LAT + 5) @(posedge clk);
    endtask

    initial begin
        n_mod   = '1;
        np_full = neg_inv(n_mod);
        n0p     = np_full[DATA_WIDTH-1:0];
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0; bus.n0prime = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_top_carry();
        test_max_operands();
        test_zero_restart();
        test_random();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
